fp_normalize_round: RTL and testbench

Parametrised, two-stage pipelined normalise-and-round unit for the FP adder datapath, the successor to the combinational normaliser. Accepts an unnormalised sum (carry, hidden, fraction, guard, round, sticky) with a biased exponent. Produces a packed IEEE-754 result under four rounding modes with overflow/underflow/inexact flags. Valid/ready handshake on both sides.

---
 rtl/fp_normalize_round_pkg.sv | 34 +++
 rtl/fp_normalize_round_if.sv | 31 +++
 rtl/fp_normalize_round_lzc.sv | 19 +
 rtl/fp_normalize_round.sv | 157 +++++++++++++++
 tb/tb_fp_normalize_round.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/fp_normalize_round_pkg.sv
// Shared FP normalise/round types: rounding modes, exponent constants, stage payload and flags.
// Pure declarations; no timing or flow-control behaviour of its own.
package fp_pkg;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } rm_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Width-independent part of the stage-1 payload; the top appends exponent and significand.
  typedef struct packed {
    logic sign;
    logic zero;
    rm_e  rm;
    logic sticky;
  } s1_ctl_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

endpackage

// File: rtl/fp_normalize_round_if.sv
// Input/output bus of the normalise-and-round unit, valid/ready on both sides.
// master = upstream/downstream environment, slave = the unit itself.
interface fp_normalize_round_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SIG_W = MAN_W + 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sign;
  logic [EXP_W-1:0]       in_exp;
  logic [SIG_W-1:0]       in_mant;
  logic                   in_sticky;
  logic [1:0]             in_rm;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   out_result;
  logic                   out_overflow;
  logic                   out_underflow;
  logic                   out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, in_rm, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky, in_rm, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fp_normalize_round_lzc.sv
// Leading-zero counter; all-zero input returns WIDTH.
// Purely combinational, no flow control.
module fp_lzc #(
  parameter int WIDTH = 26,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    cnt
);

  // Scanning upward lets the most significant set bit overwrite earlier hits.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage normalise + round to packed IEEE-754; 2-cycle latency, 1/cycle throughput.
// Stalls hold both stages under out_ready=0; FPN_SUBNORMAL_EN keeps subnormals instead of flushing.
module fp_normalize_round
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SIG_W = MAN_W + 4
) (
  input logic               clk,
  input logic               rst_n,
  fp_normalize_round_if.slave bus
);

  localparam int XW  = EXP_W + 2;
  localparam int NW  = SIG_W - 1;
  localparam int LZW = $clog2(NW + 1);
  localparam int RW  = EXP_W + MAN_W + 1;
  localparam logic [XW-1:0] EXP_MAX_X = XW'(fp_exp_max(EXP_W));

  // sig: hidden, MAN_W fraction, guard, round; exp is two's complement.
  typedef struct packed {
    s1_ctl_t       ctl;
    logic [XW-1:0] exp;
    logic [NW-1:0] sig;
  } s1_pay_t;

  logic            s1_vld_q, s1_vld_d;
  s1_pay_t         s1_q, s1_d;
  logic            out_vld_q, out_vld_d;
  logic [RW-1:0]   out_res_q, out_res_d;
  fp_flags_t       out_flg_q, out_flg_d;

  logic [LZW-1:0]  lz;
  logic [XW-1:0]   shamt;
  logic [XW-1:0]   eff_exp;
  s1_pay_t         s1_pay;

  logic            s2_adv;
  logic            in_rdy;

  logic            g, s, lsb, inc, inexact;
  logic [MAN_W+1:0] rnd;
  logic [XW-1:0]   exp_r;
  logic            hid_r;
  logic            to_inf;
  logic [RW-1:0]   rnd_res;
  fp_flags_t       rnd_flg;

  fp_lzc #(.WIDTH(NW), .CW(LZW)) u_lzc (
    .din (bus.in_mant[NW-1:0]),
    .cnt (lz)
  );

  // Stage 1: normalise so the hidden bit lands at sig[NW-1].
  always_comb begin
    shamt = XW'(lz);
`ifdef FPN_SUBNORMAL_EN
    eff_exp = (bus.in_exp == '0) ? XW'(1) : XW'(bus.in_exp);
    if (shamt > eff_exp - XW'(1)) shamt = eff_exp - XW'(1);
`else
    eff_exp = XW'(bus.in_exp);
`endif
    s1_pay          = '0;
    s1_pay.ctl.sign = bus.in_sign;
    s1_pay.ctl.zero = (bus.in_mant == '0) && !bus.in_sticky;
    s1_pay.ctl.rm   = rm_e'(bus.in_rm);
    if (bus.in_mant[SIG_W-1]) begin
      s1_pay.sig        = bus.in_mant[SIG_W-1:1];
      s1_pay.ctl.sticky = bus.in_sticky | bus.in_mant[0];
      s1_pay.exp        = XW'(bus.in_exp) + XW'(1);
    end else begin
      s1_pay.sig        = bus.in_mant[NW-1:0] << shamt;
      s1_pay.ctl.sticky = bus.in_sticky;
      s1_pay.exp        = eff_exp - shamt;
    end
  end

  // Stage 2: round, then classify zero / underflow / overflow.
  always_comb begin
    g       = s1_q.sig[1];
    s       = s1_q.sig[0] | s1_q.ctl.sticky;
    lsb     = s1_q.sig[2];
    inexact = g | s;
    case (s1_q.ctl.rm)
      RNE:     inc = g && (s || lsb);
      RTZ:     inc = 1'b0;
      RUP:     inc = !s1_q.ctl.sign && inexact;
      RDN:     inc = s1_q.ctl.sign && inexact;
      default: inc = 1'b0;
    endcase
    rnd    = {1'b0, s1_q.sig[NW-1:2]} + (MAN_W+2)'(inc);
    exp_r  = s1_q.exp + XW'(rnd[MAN_W+1]);
    hid_r  = rnd[MAN_W+1] | rnd[MAN_W];
    to_inf = (s1_q.ctl.rm == RNE) ||
             (s1_q.ctl.rm == RUP && !s1_q.ctl.sign) ||
             (s1_q.ctl.rm == RDN && s1_q.ctl.sign);

    rnd_res = '0;
    rnd_flg = '0;
    if (s1_q.ctl.zero) begin
      rnd_res = {(s1_q.ctl.rm == RDN), {(RW-1){1'b0}}};
`ifndef FPN_SUBNORMAL_EN
    end else if ($signed(s1_q.exp) <= 0 || !s1_q.sig[NW-1]) begin
      rnd_res           = {s1_q.ctl.sign, {(RW-1){1'b0}}};
      rnd_flg.underflow = 1'b1;
      rnd_flg.inexact   = 1'b1;
`endif
    end else if ($signed(exp_r) >= $signed(EXP_MAX_X)) begin
      rnd_flg.overflow = 1'b1;
      rnd_flg.inexact  = 1'b1;
      if (to_inf) rnd_res = {s1_q.ctl.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else        rnd_res = {s1_q.ctl.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end else begin
      rnd_res         = {s1_q.ctl.sign, (hid_r ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), rnd[MAN_W-1:0]};
      rnd_flg.inexact = inexact;
`ifdef FPN_SUBNORMAL_EN
      rnd_flg.underflow = !hid_r && inexact;
`endif
    end
  end

  // Pipeline control: each stage moves when its successor is empty or draining.
  always_comb begin
    s2_adv    = !out_vld_q || bus.out_ready;
    in_rdy    = !s1_vld_q || s2_adv;
    s1_vld_d  = in_rdy ? bus.in_valid : s1_vld_q;
    s1_d      = (bus.in_valid && in_rdy) ? s1_pay : s1_q;
    out_vld_d = s2_adv ? s1_vld_q : out_vld_q;
    out_res_d = (s2_adv && s1_vld_q) ? rnd_res : out_res_q;
    out_flg_d = (s2_adv && s1_vld_q) ? rnd_flg : out_flg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      out_vld_q <= 1'b0;
      out_res_q <= '0;
      out_flg_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_q      <= s1_d;
      out_vld_q <= out_vld_d;
      out_res_q <= out_res_d;
      out_flg_q <= out_flg_d;
    end
  end

  assign bus.in_ready      = in_rdy;
  assign bus.out_valid     = out_vld_q;
  assign bus.out_result    = out_res_q;
  assign bus.out_overflow  = out_flg_q.overflow;
  assign bus.out_underflow = out_flg_q.underflow;
  assign bus.out_inexact   = out_flg_q.inexact;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round at default single-precision parameters.
module tb_fp_normalize_round;
  import fp_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  fp_normalize_round_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_normalize_round #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic drive(input logic sgn, input logic [7:0] e, input logic [26:0] m,
                       input logic stk, input logic [1:0] rm);
    bus.in_sign   = sgn;
    bus.in_exp    = e;
    bus.in_mant   = m;
    bus.in_sticky = stk;
    bus.in_rm     = rm;
  endtask

  task automatic run_vec(input string tag, input logic sgn, input logic [7:0] e,
                         input logic [26:0] m, input logic stk, input logic [1:0] rm,
                         input logic [31:0] w_res, input logic w_ovf, input logic w_udf,
                         input logic w_inx);
    int n;
    @(negedge clk);
    drive(sgn, e, m, stk, rm);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    check({tag, "/lat"}, 32'(n), 32'd2);
    check({tag, "/res"}, bus.out_result, w_res);
    check({tag, "/ovf"}, 32'(bus.out_overflow), 32'(w_ovf));
    check({tag, "/udf"}, 32'(bus.out_underflow), 32'(w_udf));
    check({tag, "/inx"}, 32'(bus.out_inexact), 32'(w_inx));
  endtask

  logic [31:0] bp_exp [3];
  int          got;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 8'd0, 27'd0, 1'b0, 2'd0);
    #12;
    check("rst/vld", 32'(bus.out_valid), 32'd0);
    check("rst/res", bus.out_result, 32'd0);
    check("rst/flags", {29'd0, bus.out_overflow, bus.out_underflow, bus.out_inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/rdy", 32'(bus.in_ready), 32'd1);

    run_vec("one",      1'b0, 8'd127, 27'h2000000, 1'b0, 2'd0, 32'h3F800000, 0, 0, 0);
    run_vec("carry",    1'b0, 8'd127, 27'h4000000, 1'b0, 2'd0, 32'h40000000, 0, 0, 0);
    run_vec("cancel",   1'b0, 8'd127, 27'h1000000, 1'b0, 2'd0, 32'h3F000000, 0, 0, 0);
    run_vec("zero_rdn", 1'b0, 8'd127, 27'h0000000, 1'b0, 2'd3, 32'h80000000, 0, 0, 0);
    run_vec("zero_rne", 1'b1, 8'd127, 27'h0000000, 1'b0, 2'd0, 32'h00000000, 0, 0, 0);
    run_vec("tie_rne",  1'b0, 8'd127, 27'h3FFFFFE, 1'b0, 2'd0, 32'h40000000, 0, 0, 1);
    run_vec("tie_rtz",  1'b0, 8'd127, 27'h3FFFFFE, 1'b0, 2'd1, 32'h3FFFFFFF, 0, 0, 1);
    run_vec("rup_pos",  1'b0, 8'd127, 27'h2000001, 1'b0, 2'd2, 32'h3F800001, 0, 0, 1);
    run_vec("rdn_pos",  1'b0, 8'd127, 27'h2000001, 1'b0, 2'd3, 32'h3F800000, 0, 0, 1);
    run_vec("rup_neg",  1'b1, 8'd127, 27'h2000000, 1'b1, 2'd2, 32'hBF800000, 0, 0, 1);
    run_vec("ovf_rne",  1'b0, 8'd254, 27'h4000000, 1'b0, 2'd0, 32'h7F800000, 1, 0, 1);
    run_vec("ovf_rtz",  1'b0, 8'd254, 27'h4000000, 1'b0, 2'd1, 32'h7F7FFFFF, 1, 0, 1);
    run_vec("ovf_nrup", 1'b1, 8'd254, 27'h4000000, 1'b0, 2'd2, 32'hFF7FFFFF, 1, 0, 1);
    run_vec("ovf_nrdn", 1'b1, 8'd254, 27'h4000000, 1'b0, 2'd3, 32'hFF800000, 1, 0, 1);
`ifdef FPN_SUBNORMAL_EN
    run_vec("tiny",     1'b0, 8'd1,   27'h1000000, 1'b0, 2'd0, 32'h00400000, 0, 0, 0);
`else
    run_vec("tiny",     1'b0, 8'd1,   27'h1000000, 1'b0, 2'd0, 32'h00000000, 0, 1, 1);
`endif

    // Backpressure: three beats offered while the output is stalled.
    bp_exp[0] = 32'h3F800000;
    bp_exp[1] = 32'h40000000;
    bp_exp[2] = 32'h3F000000;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b0, 8'd127, 27'h2000000, 1'b0, 2'd0);
    bus.in_valid = 1'b1;
    #1 check("bp/rdy_a", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 drive(1'b0, 8'd127, 27'h4000000, 1'b0, 2'd0);
    @(negedge clk);
    check("bp/rdy_b", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 drive(1'b0, 8'd127, 27'h1000000, 1'b0, 2'd0);
    @(negedge clk);
    check("bp/rdy_c0", 32'(bus.in_ready), 32'd0);
    check("bp/vld", 32'(bus.out_valid), 32'd1);
    check("bp/hold0", bus.out_result, bp_exp[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("bp/rdy_c1", 32'(bus.in_ready), 32'd0);
    check("bp/hold1", bus.out_result, bp_exp[0]);
    bus.out_ready = 1'b1;
    #1 check("bp/rdy_c2", 32'(bus.in_ready), 32'd1);
    got = 0;
    for (int c = 0; c < 8 && got < 3; c++) begin
      if (bus.out_valid) begin
        check($sformatf("bp/out%0d", got), bus.out_result, bp_exp[got]);
        got++;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
    end
    check("bp/count", 32'(got), 32'd3);
    check("bp/drained", 32'(bus.out_valid), 32'd0);

    // Reset with both stages occupied.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b0, 8'd127, 27'h2000000, 1'b0, 2'd0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 drive(1'b1, 8'd127, 27'h4000000, 1'b0, 2'd0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst2/full", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst2/vld", 32'(bus.out_valid), 32'd0);
    check("rst2/res", bus.out_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst2/stale%0d", c), 32'(bus.out_valid), 32'd0);
    end
    check("rst2/rdy", 32'(bus.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
